// File: rtl/i_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// i_wr_addr_gen : 2-D raster address generator with valid/ready SRAM handshake
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i_wr_addr_gen #(
   parameter int COL_W  = 13,
   parameter int ROW_W  = 13,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic              clear,
   input  logic [COL_W-1:0]  img_width,
   input  logic [ROW_W-1:0]  img_height,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] row_stride,
   input  logic              addr_ready,
   output logic              addr_valid,
   output logic [ADDR_W-1:0] addr,
   output logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  row,
   output logic              row_end,
   output logic              frame_last,
   output logic              frame_done,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              w_accept;
   logic              w_dims_ok;
   logic              w_beat;
   logic              w_row_end;
   logic              w_frame_last;

   logic [COL_W-1:0]  r_width;
   logic [ROW_W-1:0]  r_height;
   logic [ADDR_W-1:0] r_stride;
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_addr;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;

   assign w_dims_ok    = (img_width != '0) && (img_height != '0);
   assign addr_valid   = (r_state == ST_RUN);
   assign w_beat       = addr_valid && addr_ready;
   // Compares use the latched geometry, so width-1 never underflows in RUN.
   assign w_row_end    = addr_valid && (r_col == r_width - COL_W'(1));
   assign w_frame_last = w_row_end && (r_row == r_height - ROW_W'(1));

   assign addr       = r_addr;
   assign col        = r_col;
   assign row        = r_row;
   assign row_end    = w_row_end;
   assign frame_last = w_frame_last;
   assign frame_done = (r_state == ST_DONE);
   assign busy       = (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      if (clear) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_accept     = 1'b1;
                  w_state_next = w_dims_ok ? ST_RUN : ST_DONE;
               end
            end
            ST_RUN: begin
               if (w_beat && w_frame_last) begin
                  w_state_next = ST_DONE;
               end
            end
            ST_DONE: begin
               w_state_next = ST_IDLE;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_width    <= '0;
         r_height   <= '0;
         r_stride   <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_col      <= '0;
         r_row      <= '0;
      end else if (clear) begin
         r_row_base <= '0;
         r_addr     <= '0;
         r_col      <= '0;
         r_row      <= '0;
      end else if (w_accept) begin
         r_width    <= img_width;
         r_height   <= img_height;
         r_stride   <= row_stride;
         r_col      <= '0;
         r_row      <= '0;
         // A degenerate frame issues no beats, so the address stays at zero.
         r_row_base <= w_dims_ok ? base_addr : '0;
         r_addr     <= w_dims_ok ? base_addr : '0;
      end else if (w_beat) begin
         if (w_frame_last) begin
            r_row_base <= '0;
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
         end else if (w_row_end) begin
            r_col      <= '0;
            r_row      <= r_row + ROW_W'(1);
            r_row_base <= r_row_base + r_stride;
            r_addr     <= r_row_base + r_stride;
         end else begin
            r_col      <= r_col + COL_W'(1);
            r_addr     <= r_addr + ADDR_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_i_wr_addr_gen : table vectors, corner sequences and random frames
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_i_wr_addr_gen;

   localparam int COL_W  = 13;
   localparam int ROW_W  = 13;
   localparam int ADDR_W = 20;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              start;
   logic              clear;
   logic [COL_W-1:0]  img_width;
   logic [ROW_W-1:0]  img_height;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] row_stride;
   logic              addr_ready;
   logic              addr_valid;
   logic [ADDR_W-1:0] addr;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              row_end;
   logic              frame_last;
   logic              frame_done;
   logic              busy;

   int compared   = 0;
   int mismatched = 0;

   i_wr_addr_gen #(.COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .clear(clear),
      .img_width(img_width), .img_height(img_height),
      .base_addr(base_addr), .row_stride(row_stride),
      .addr_ready(addr_ready), .addr_valid(addr_valid), .addr(addr),
      .col(col), .row(row), .row_end(row_end), .frame_last(frame_last),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                w;
      int                h;
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] stride;
      logic [ADDR_W-1:0] exp_last;
      int                exp_cycles;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] a;
      int                c;
      int                r;
      bit                re;
      bit                fl;
   } beat_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic apply_start(input int w, input int h,
                              input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s);
      img_width  = COL_W'(w);
      img_height = ROW_W'(h);
      base_addr  = b;
      row_stride = s;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_valid"}, 32'(addr_valid), 32'd0);
      chk({tag, "_addr"},  32'(addr),       32'd0);
      chk({tag, "_col"},   32'(col),        32'd0);
      chk({tag, "_row"},   32'(row),        32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
      chk({tag, "_done"},  32'(frame_done), 32'd0);
      chk({tag, "_flags"}, 32'({row_end, frame_last}), 32'd0);
   endtask

   // Expected beats come from raster arithmetic: base + row*stride + col.
   task automatic run_frame(input int w, input int h,
                            input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                            input int pct, input bit scramble,
                            input int hold_beat, input int hold_n,
                            output logic [ADDR_W-1:0] last_addr, output int cyc);
      beat_t q[$];
      beat_t e;
      int    idx   = 0;
      int    held  = 0;
      int    total = w * h;
      bit    rdy;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            e.a  = ADDR_W'(32'(b) + 32'(s) * r + c);
            e.c  = c;
            e.r  = r;
            e.re = (c == w - 1);
            e.fl = (c == w - 1) && (r == h - 1);
            q.push_back(e);
         end
      end
      last_addr = '0;
      cyc       = 0;
      apply_start(w, h, b, s);
      while (idx < total && cyc < total * 40 + 50) begin
         if (idx == hold_beat && held < hold_n) begin
            rdy = 1'b0;
            held++;
         end else begin
            rdy = ($urandom_range(0, 99) < pct);
         end
         addr_ready = rdy;
         if (scramble) begin
            start      = 1'($urandom_range(0, 1));
            img_width  = COL_W'($urandom);
            img_height = ROW_W'($urandom);
            base_addr  = ADDR_W'($urandom);
            row_stride = ADDR_W'($urandom);
         end
         @(negedge clk);
         e = q[idx];
         chk("beat_valid", 32'(addr_valid), 32'd1);
         chk("beat_addr",  32'(addr),       32'(e.a));
         chk("beat_col",   32'(col),        32'(e.c));
         chk("beat_row",   32'(row),        32'(e.r));
         chk("beat_rowend", 32'(row_end),   32'(e.re));
         chk("beat_last",  32'(frame_last), 32'(e.fl));
         chk("beat_nodone", 32'(frame_done), 32'd0);
         if (rdy) begin
            last_addr = addr;
            idx++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      if (idx < total) chk("frame_timeout", 32'(idx), 32'(total));
      start = scramble;
      @(negedge clk);
      chk("done_pulse", 32'(frame_done), 32'd1);
      chk("done_valid", 32'(addr_valid), 32'd0);
      chk("done_busy",  32'(busy),       32'd1);
      @(posedge clk); #1;
      start      = 1'b0;
      addr_ready = 1'b0;
      @(negedge clk);
      chk("post_done", 32'(frame_done), 32'd0);
      chk("post_busy", 32'(busy),       32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t              vecs[$];
      logic [ADDR_W-1:0] la;
      int                cyc;

      n_rst = 1'b0; start = 1'b0; clear = 1'b0; addr_ready = 1'b0;
      img_width = '0; img_height = '0; base_addr = '0; row_stride = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset");
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;

      vecs.push_back('{3, 2, 20'h00100, 20'h00010, 20'h00112, 6});
      vecs.push_back('{1, 1, 20'h00005, 20'h00000, 20'h00005, 1});
      vecs.push_back('{4, 1, 20'hFFFFE, 20'h00000, 20'h00001, 4});
      vecs.push_back('{0, 5, 20'h00123, 20'h00010, 20'h00000, 0});
      vecs.push_back('{5, 0, 20'h00123, 20'h00010, 20'h00000, 0});
      vecs.push_back('{2, 3, 20'hFFFF0, 20'h00008, 20'h00001, 6});
      vecs.push_back('{8191, 1, 20'h00000, 20'h00000, 20'h01FFE, 8191});
      foreach (vecs[i]) begin
         run_frame(vecs[i].w, vecs[i].h, vecs[i].base, vecs[i].stride,
                   100, 1'b0, -1, 0, la, cyc);
         chk($sformatf("vec%0d_last", i),   32'(la),  32'(vecs[i].exp_last));
         chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      end

      // Backpressure: ready low for 4 cycles while beat 2 is presented.
      run_frame(3, 2, 20'h00100, 20'h00010, 100, 1'b0, 1, 4, la, cyc);
      chk("bp_cycles", 32'(cyc), 32'd10);
      chk("bp_last",   32'(la),  32'h112);

      // Abort with clear on beat 3 of a 4x4 frame.
      addr_ready = 1'b1;
      apply_start(4, 4, 20'h00200, 20'h00040);
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk); @(posedge clk); #1;
      clear = 1'b1;
      @(negedge clk);
      chk("abort_beat3", 32'(addr), 32'h202);
      @(posedge clk); #1;
      clear = 1'b0;
      addr_ready = 1'b0;
      @(negedge clk);
      check_idle_zero("abort");
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_nodone", 32'(frame_done), 32'd0);
      @(posedge clk); #1;
      run_frame(4, 4, 20'h00200, 20'h00040, 100, 1'b0, -1, 0, la, cyc);
      chk("restart_last", 32'(la), 32'h2C3);

      // clear and start together in IDLE: start is dropped.
      img_width = 13'd2; img_height = 13'd2;
      clear = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("clrstart_busy",  32'(busy),       32'd0);
      chk("clrstart_valid", 32'(addr_valid), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a frame.
      addr_ready = 1'b1;
      apply_start(4, 4, 20'h00300, 20'h00100);
      repeat (3) @(posedge clk);
      #2 n_rst = 1'b0;
      #1 check_idle_zero("async_rst");
      @(posedge clk); #1;
      n_rst = 1'b1;
      addr_ready = 1'b0;
      @(negedge clk);
      chk("rst_nodone", 32'(frame_done), 32'd0);
      @(posedge clk); #1;

      // Mid-frame start pulses and config changes must not disturb the frame.
      run_frame(3, 3, 20'h00400, 20'h00020, 70, 1'b1, -1, 0, la, cyc);
      chk("scramble_last", 32'(la), 32'h442);

      for (int k = 0; k < 12; k++) begin
         run_frame($urandom_range(0, 6), $urandom_range(0, 4),
                   ADDR_W'($urandom), ADDR_W'($urandom),
                   $urandom_range(30, 100), 1'($urandom_range(0, 1)),
                   -1, 0, la, cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
